// File: rtl/grade_mac_seq_if.sv
// ap_ctrl_hs handshake and operand bus for grade_mac_seq.
// The master drives the request and operands, and the slave returns the handshake and grade.
interface grade_mac_seq_if #(
    parameter int unsigned N_CH     = 5,
    parameter int unsigned SCORE_W  = 32,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = SCORE_W + WEIGHT_W + $clog2(N_CH + 1)
);
    logic                       ap_start;
    logic                       ap_done;
    logic                       ap_idle;
    logic                       ap_ready;
    logic [N_CH*SCORE_W-1:0]    scores;
    logic [N_CH*WEIGHT_W-1:0]   weights;
    logic [4*ACC_W-1:0]         thr;
    logic [7:0]                 ap_return;

    modport master (
        output ap_start, scores, weights, thr,
        input  ap_done, ap_idle, ap_ready, ap_return
    );

    modport slave (
        input  ap_start, scores, weights, thr,
        output ap_done, ap_idle, ap_ready, ap_return
    );
endinterface

// File: rtl/grade_mac_seq.sv
// Sequential weighted-sum grader. It uses one MAC per channel per cycle and an ap_ctrl_hs handshake.
// Define GRADE_KEY_LOCK_EN to add the working_key port, which obfuscates the grade unless the key is correct.
module grade_mac_seq #(
    parameter int unsigned N_CH     = 5,
    parameter int unsigned SCORE_W  = 32,
    parameter int unsigned WEIGHT_W = 8,
    parameter int unsigned ACC_W    = SCORE_W + WEIGHT_W + $clog2(N_CH + 1)
`ifdef GRADE_KEY_LOCK_EN
    ,
    parameter int unsigned   KEY_W       = 255,
    parameter logic [KEY_W-1:0] CORRECT_KEY = '0
`endif
) (
    input logic ap_clk,
    input logic ap_rst_n,
`ifdef GRADE_KEY_LOCK_EN
    input logic [KEY_W-1:0] working_key,
`endif
    grade_mac_seq_if.slave bus
);
    localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PROD_W = SCORE_W + WEIGHT_W;

    typedef enum logic [1:0] {StIdle, StMac, StClassify, StDone} state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         idx_q;
    logic [ACC_W-1:0]         acc_q;
    logic [N_CH*SCORE_W-1:0]  scores_q;
    logic [N_CH*WEIGHT_W-1:0] weights_q;
    logic [4*ACC_W-1:0]       thr_q;
    logic [7:0]               ret_q;
    logic                     done_q;
`ifdef GRADE_KEY_LOCK_EN
    logic [7:0]               key_mask_q;
`endif

    logic [SCORE_W-1:0]  score_sel;
    logic [WEIGHT_W-1:0] weight_sel;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]    acc_d;
    logic [7:0]          grade;
    logic [7:0]          ret_d;

    always_comb begin
        score_sel  = scores_q[idx_q*SCORE_W +: SCORE_W];
        weight_sel = weights_q[idx_q*WEIGHT_W +: WEIGHT_W];
        prod       = PROD_W'(score_sel) * PROD_W'(weight_sel);
        acc_d      = acc_q + ACC_W'(prod);
    end

    // Priority A->D keeps the result defined even for unsorted thresholds.
    always_comb begin
        grade = 8'h46;
        if (acc_q >= thr_q[3*ACC_W +: ACC_W])      grade = 8'h41;
        else if (acc_q >= thr_q[2*ACC_W +: ACC_W]) grade = 8'h42;
        else if (acc_q >= thr_q[1*ACC_W +: ACC_W]) grade = 8'h43;
        else if (acc_q >= thr_q[0*ACC_W +: ACC_W]) grade = 8'h44;
`ifdef GRADE_KEY_LOCK_EN
        ret_d = grade ^ key_mask_q;
`else
        ret_d = grade;
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            ret_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.ap_start) begin
                        scores_q  <= bus.scores;
                        weights_q <= bus.weights;
                        thr_q     <= bus.thr;
`ifdef GRADE_KEY_LOCK_EN
                        key_mask_q <= (working_key == CORRECT_KEY) ? 8'h00
                                    : (working_key[7:0] ^ CORRECT_KEY[7:0]);
`endif
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_W'(N_CH - 1)) begin
                        state_q <= StClassify;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StClassify: begin
                    ret_q   <= ret_d;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ap_done   = done_q;
    assign bus.ap_idle   = (state_q == StIdle);
    assign bus.ap_ready  = (state_q == StIdle) && bus.ap_start;
    assign bus.ap_return = ret_q;
endmodule

// File: tb/tb_grade_mac_seq.sv
// Directed-vector bench for grade_mac_seq. It covers grades, boundaries, reset abort, back-to-back runs and max operands.
module tb_grade_mac_seq;
    localparam int unsigned N_CH     = 5;
    localparam int unsigned SCORE_W  = 32;
    localparam int unsigned WEIGHT_W = 8;
    localparam int unsigned ACC_W    = SCORE_W + WEIGHT_W + $clog2(N_CH + 1);

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    grade_mac_seq_if #(
        .N_CH(N_CH), .SCORE_W(SCORE_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
    ) bus ();

`ifdef GRADE_KEY_LOCK_EN
    logic [254:0] working_key = '0;
`endif

    grade_mac_seq #(
        .N_CH(N_CH), .SCORE_W(SCORE_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
`ifdef GRADE_KEY_LOCK_EN
        .working_key(working_key),
`endif
        .bus        (bus)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1);
    end

    task automatic set_inputs(input logic [SCORE_W-1:0] s, input logic [WEIGHT_W-1:0] w,
                              input logic [ACC_W-1:0] ta, input logic [ACC_W-1:0] tb_,
                              input logic [ACC_W-1:0] tc, input logic [ACC_W-1:0] td);
        for (int i = 0; i < N_CH; i++) begin
            bus.scores[i*SCORE_W +: SCORE_W]    = s;
            bus.weights[i*WEIGHT_W +: WEIGHT_W] = w;
        end
        bus.thr = {ta, tb_, tc, td};
    endtask

    // One full run. Inputs are scrambled right after accept, which must not affect the result.
    task automatic run_vec(input string name, input logic [SCORE_W-1:0] s,
                           input logic [WEIGHT_W-1:0] w, input logic [ACC_W-1:0] ta,
                           input logic [ACC_W-1:0] tb_, input logic [ACC_W-1:0] tc,
                           input logic [ACC_W-1:0] td, input logic [7:0] expected);
        int cyc;
        @(negedge ap_clk);
        set_inputs(s, w, ta, tb_, tc, td);
        bus.ap_start = 1'b1;
        #1;
        vectors++;
        if (bus.ap_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready: got %b expected 1", name, bus.ap_ready);
        end
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        set_inputs('1, '1, '1, '1, '1, '1);
        cyc = 1;
        while (bus.ap_done !== 1'b1 && cyc < 20) begin
            @(negedge ap_clk);
            cyc++;
        end
        vectors++;
        if (cyc != N_CH + 2) begin
            miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, N_CH + 2);
        end
        vectors++;
        if (bus.ap_return !== expected) begin
            miscompares++;
            $display("FAIL %s grade: got %h expected %h", name, bus.ap_return, expected);
        end
        vectors++;
        if (bus.ap_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_in_done: got %b expected 0", name, bus.ap_idle);
        end
        @(negedge ap_clk);
        vectors++;
        if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_width: got done=%b idle=%b expected done=0 idle=1",
                     name, bus.ap_done, bus.ap_idle);
        end
    endtask

    task automatic test_reset();
        bus.ap_start = 1'b0;
        set_inputs('0, '0, '0, '0, '0, '0);
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        vectors++;
        if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0 ||
            bus.ap_return !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got idle=%b done=%b ready=%b ret=%h expected 1 0 0 00",
                     bus.ap_idle, bus.ap_done, bus.ap_ready, bus.ap_return);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        vectors++;
        if (bus.ap_idle !== 1'b1 || bus.ap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got idle=%b done=%b expected 1 0",
                     bus.ap_idle, bus.ap_done);
        end
    endtask

    task automatic test_grades();
        run_vec("a_450", 32'd90, 8'd1, 400, 350, 300, 250, 8'h41);
        run_vec("c_300_incl", 32'd60, 8'd1, 400, 350, 300, 250, 8'h43);
        run_vec("f_200", 32'd40, 8'd1, 400, 350, 300, 250, 8'h46);
        run_vec("d_250_incl", 32'd50, 8'd1, 400, 350, 300, 250, 8'h44);
        run_vec("b_350_w2", 32'd35, 8'd2, 400, 350, 300, 250, 8'h42);
        run_vec("zero_thr0", 32'd0, 8'd0, 0, 0, 0, 0, 8'h41);
        run_vec("unsorted_b", 32'd90, 8'd1, 1000, 100, 500, 0, 8'h42);
        repeat (3) @(negedge ap_clk);
        vectors++;
        if (bus.ap_return !== 8'h42) begin
            miscompares++;
            $display("FAIL hold_return: got %h expected 42", bus.ap_return);
        end
    endtask

    task automatic test_reset_mid_mac();
        logic seen_done;
        @(negedge ap_clk);
        set_inputs(32'd90, 8'd1, 400, 350, 300, 250);
        bus.ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        bus.ap_start = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        vectors++;
        if (bus.ap_idle !== 1'b1 || bus.ap_return !== 8'h00 || bus.ap_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got idle=%b ret=%h done=%b expected 1 00 0",
                     bus.ap_idle, bus.ap_return, bus.ap_done);
        end
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge ap_clk);
            seen_done = seen_done | bus.ap_done;
        end
        vectors++;
        if (seen_done !== 1'b0 || bus.ap_return !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_no_done: got done_seen=%b ret=%h expected 0 00",
                     seen_done, bus.ap_return);
        end
    endtask

    task automatic test_back_to_back();
        logic [SCORE_W-1:0] sc [3];
        logic [7:0]         ex [3];
        int ready_c [3];
        int done_c [3];
        int nr, nd, ndone;
        sc = '{32'd90, 32'd40, 32'd60};
        ex = '{8'h41, 8'h46, 8'h43};
        nr = 0; nd = 0; ndone = 0;
        @(negedge ap_clk);
        set_inputs(sc[0], 8'd1, 400, 350, 300, 250);
        bus.ap_start = 1'b1;
        for (int c = 0; c < 28; c++) begin
            if (c > 0) @(negedge ap_clk);
            if (nr == 3) bus.ap_start = 1'b0;
            if (nr > 0 && nr < 3) set_inputs(sc[nr], 8'd1, 400, 350, 300, 250);
            #1;
            if (bus.ap_ready === 1'b1 && nr < 3) begin
                ready_c[nr] = c;
                nr++;
            end
            if (bus.ap_done === 1'b1) begin
                ndone++;
                if (nd < 3) begin
                    done_c[nd] = c;
                    vectors++;
                    if (bus.ap_return !== ex[nd]) begin
                        miscompares++;
                        $display("FAIL b2b_grade%0d: got %h expected %h", nd, bus.ap_return,
                                 ex[nd]);
                    end
                    nd++;
                end
            end
        end
        vectors++;
        if (nr != 3 || ndone != 3) begin
            miscompares++;
            $display("FAIL b2b_counts: got ready=%0d done=%0d expected 3 3", nr, ndone);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (done_c[k] - ready_c[k] != N_CH + 2) begin
                    miscompares++;
                    $display("FAIL b2b_latency%0d: got %0d expected %0d", k,
                             done_c[k] - ready_c[k], N_CH + 2);
                end
            end
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (ready_c[k] - ready_c[k-1] != N_CH + 3) begin
                    miscompares++;
                    $display("FAIL b2b_period%0d: got %0d expected %0d", k,
                             ready_c[k] - ready_c[k-1], N_CH + 3);
                end
            end
        end
        bus.ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
    endtask

    task automatic test_max_operands();
        // 5 * (2^32-1) * 255, the largest reachable sum
        logic [ACC_W-1:0] max_acc;
        max_acc = ACC_W'(5) * ACC_W'(40'hFE_FFFF_FF01);
        run_vec("max_a", 32'hFFFF_FFFF, 8'hFF, max_acc, 0, 0, 0, 8'h41);
        run_vec("max_plus1_b", 32'hFFFF_FFFF, 8'hFF, max_acc + 1'b1, 0, 0, 0, 8'h42);
    endtask

`ifdef GRADE_KEY_LOCK_EN
    task automatic test_key_lock();
        working_key = 255'h07;
        run_vec("key_wrong", 32'd90, 8'd1, 400, 350, 300, 250, 8'h46);
        working_key = '0;
        run_vec("key_right", 32'd90, 8'd1, 400, 350, 300, 250, 8'h41);
    endtask
`endif

    initial begin
        test_reset();
        test_grades();
        test_reset_mid_mac();
        test_back_to_back();
        test_max_operands();
`ifdef GRADE_KEY_LOCK_EN
        test_key_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
